// File: rtl/alu_pkg.sv
// Shared ALU op codes, instruction field constants and widths for the
// ID/EX issue stage and the ALU.
package alu_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned SHW  = 6;
  localparam int unsigned OPCW = 6;
  localparam int unsigned FNW  = 6;

  localparam logic [OPW-1:0] ALU_NOP = 4'd0;
  localparam logic [OPW-1:0] ALU_ADD = 4'd1;
  localparam logic [OPW-1:0] ALU_SUB = 4'd2;
  localparam logic [OPW-1:0] ALU_AND = 4'd3;
  localparam logic [OPW-1:0] ALU_OR  = 4'd4;
  localparam logic [OPW-1:0] ALU_XOR = 4'd5;
  localparam logic [OPW-1:0] ALU_LUI = 4'd6;
  localparam logic [OPW-1:0] ALU_SLT = 4'd7;
  localparam logic [OPW-1:0] ALU_SLL = 4'd8;
  localparam logic [OPW-1:0] ALU_SRL = 4'd9;

  localparam logic [OPCW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCW-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPCW-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCW-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCW-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPCW-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCW-1:0] OP_LW    = 6'h23;
  localparam logic [OPCW-1:0] OP_SW    = 6'h2B;

  localparam logic [FNW-1:0] FN_SLL  = 6'h00;
  localparam logic [FNW-1:0] FN_SRL  = 6'h02;
  localparam logic [FNW-1:0] FN_ADD  = 6'h20;
  localparam logic [FNW-1:0] FN_ADDU = 6'h21;
  localparam logic [FNW-1:0] FN_SUB  = 6'h22;
  localparam logic [FNW-1:0] FN_SUBU = 6'h23;
  localparam logic [FNW-1:0] FN_AND  = 6'h24;
  localparam logic [FNW-1:0] FN_OR   = 6'h25;
  localparam logic [FNW-1:0] FN_XOR  = 6'h26;
  localparam logic [FNW-1:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass: EX/MEM result beats MEM/WB data; register 0 never forwards.
module fwd_mux #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] reg_idx,
  input  logic [DW-1:0] reg_val,
  input  logic          exm_wr_en,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_res,
  input  logic          mwb_wr_en,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] fwd_val
);

  always_comb begin
    fwd_val = reg_val;
    if (reg_idx != '0) begin
      if (exm_wr_en && exm_rd == reg_idx) fwd_val = exm_res;
      else if (mwb_wr_en && mwb_rd == reg_idx) fwd_val = mwb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the ID instruction into ALU controls, registers
// it into ID/EX, forwards operands and raises load-use stalls.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_instr,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic          stall_in,
  input  logic          flush_in,
  input  logic          exm_wr_en,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_res,
  input  logic          mwb_wr_en,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic          stall_req,
  output logic          ex_valid,
  output logic [3:0]    alu_ctrl,
  output logic [5:0]    shamt,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [RW-1:0] ex_rd,
  output logic          ex_wr_en,
  output logic          ex_is_load,
  output logic          ex_is_store,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_illegal
);

  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  alu_ctrl;
    logic [SHW-1:0]  shamt;
    logic [RW-1:0]   rd;
    logic            wr_en;
    logic            is_load;
    logic            is_store;
    logic            illegal;
    logic            use_imm;
    logic [DW-1:0]   imm;
    logic [RW-1:0]   src1_idx;
    logic [DW-1:0]   src1_val;
    logic [RW-1:0]   rt_idx;
    logic [DW-1:0]   rt_val;
  } idex_t;

  idex_t idex_q, idex_d, dec;
  logic  rs_used, rt_used;

  logic [OPCW-1:0] opcode;
  logic [FNW-1:0]  funct;
  logic [RW-1:0]   rs, rt, rd;
  logic [DW-1:0]   sext_imm, zext_imm;
  logic [DW-1:0]   data2_reg;

  assign opcode   = id_instr[31:26];
  assign rs       = id_instr[25:21];
  assign rt       = id_instr[20:16];
  assign rd       = id_instr[15:11];
  assign funct    = id_instr[5:0];
  assign sext_imm = {{(DW-16){id_instr[15]}}, id_instr[15:0]};
  assign zext_imm = {{(DW-16){1'b0}}, id_instr[15:0]};

  always_comb begin
    dec          = '0;
    rs_used      = 1'b0;
    rt_used      = 1'b0;
    dec.valid    = 1'b1;
    dec.shamt    = {1'b0, id_instr[10:6]};
    dec.src1_idx = rs;
    dec.src1_val = id_rs_val;
    dec.rt_idx   = rt;
    dec.rt_val   = id_rt_val;
    case (opcode)
      OP_RTYPE: begin
        dec.rd    = rd;
        dec.wr_en = 1'b1;
        rs_used   = 1'b1;
        rt_used   = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_ctrl = ALU_SUB;
          FN_AND:          dec.alu_ctrl = ALU_AND;
          FN_OR:           dec.alu_ctrl = ALU_OR;
          FN_XOR:          dec.alu_ctrl = ALU_XOR;
          FN_SLT:          dec.alu_ctrl = ALU_SLT;
          FN_SLL, FN_SRL: begin
            // The ALU shifts data1, so rt is steered onto the operand-1 path.
            dec.alu_ctrl = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            dec.src1_idx = rt;
            dec.src1_val = id_rt_val;
            rs_used      = 1'b0;
          end
          default: begin
            dec.rd      = '0;
            dec.wr_en   = 1'b0;
            dec.illegal = 1'b1;
            rs_used     = 1'b0;
            rt_used     = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: begin
        dec.alu_ctrl = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        dec.use_imm  = 1'b1;
        dec.imm      = sext_imm;
        dec.rd       = rt;
        dec.wr_en    = 1'b1;
        dec.is_load  = (opcode == OP_LW);
        rs_used      = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.alu_ctrl = (opcode == OP_ANDI) ? ALU_AND :
                       (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
        dec.use_imm  = 1'b1;
        dec.imm      = zext_imm;
        dec.rd       = rt;
        dec.wr_en    = 1'b1;
        rs_used      = 1'b1;
      end
      OP_LUI: begin
        dec.alu_ctrl = ALU_LUI;
        dec.use_imm  = 1'b1;
        dec.imm      = zext_imm;
        dec.rd       = rt;
        dec.wr_en    = 1'b1;
      end
      OP_SW: begin
        dec.alu_ctrl = ALU_ADD;
        dec.use_imm  = 1'b1;
        dec.imm      = sext_imm;
        dec.is_store = 1'b1;
        rs_used      = 1'b1;
        rt_used      = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_ctrl = ALU_SUB;
        rs_used      = 1'b1;
        rt_used      = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == '0) dec.wr_en = 1'b0;
  end

  assign stall_req = idex_q.valid && idex_q.is_load && (idex_q.rd != '0) && id_valid &&
                     ((rs_used && idex_q.rd == rs) || (rt_used && idex_q.rd == rt));

  always_comb begin
    idex_d = idex_q;
    if (flush_in)                     idex_d = '0;
    else if (stall_in)                idex_d = idex_q;
    else if (stall_req || !id_valid)  idex_d = '0;
    else                              idex_d = dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_data1 (
    .reg_idx(idex_q.src1_idx), .reg_val(idex_q.src1_val),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_res(exm_res),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .fwd_val(data1)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_data2 (
    .reg_idx(idex_q.rt_idx), .reg_val(idex_q.rt_val),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_res(exm_res),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .fwd_val(data2_reg)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_store (
    .reg_idx(idex_q.rt_idx), .reg_val(idex_q.rt_val),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_res(exm_res),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .fwd_val(ex_store_data)
  );

  assign data2       = idex_q.use_imm ? idex_q.imm : data2_reg;
  assign ex_valid    = idex_q.valid;
  assign alu_ctrl    = idex_q.alu_ctrl;
  assign shamt       = idex_q.shamt;
  assign ex_rd       = idex_q.rd;
  assign ex_wr_en    = idex_q.wr_en;
  assign ex_is_load  = idex_q.is_load;
  assign ex_is_store = idex_q.is_store;
  assign ex_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr, id_rs_val, id_rt_val;
  logic        stall_in, flush_in;
  logic        exm_wr_en, mwb_wr_en;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_res, mwb_data;
  logic        stall_req, ex_valid, ex_wr_en, ex_is_load, ex_is_store, ex_illegal;
  logic [3:0]  alu_ctrl;
  logic [5:0]  shamt;
  logic [31:0] data1, data2, ex_store_data;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .stall_in(stall_in),
    .flush_in(flush_in), .exm_wr_en(exm_wr_en), .exm_rd(exm_rd),
    .exm_res(exm_res), .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd),
    .mwb_data(mwb_data), .stall_req(stall_req), .ex_valid(ex_valid),
    .alu_ctrl(alu_ctrl), .shamt(shamt), .data1(data1), .data2(data2),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_store_data(ex_store_data),
    .ex_illegal(ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic clear_fwd();
    exm_wr_en = 1'b0; exm_rd = '0; exm_res = '0;
    mwb_wr_en = 1'b0; mwb_rd = '0; mwb_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_rs_val = '0; id_rt_val = '0;
    stall_in = 1'b0; flush_in = 1'b0;
    clear_fwd();
    repeat (2) @(negedge clk);
    check("rst_valid", ex_valid, 0);
    check("rst_alu", alu_ctrl, 0);
    check("rst_data1", data1, 0);
    check("rst_data2", data2, 0);
    check("rst_stall", stall_req, 0);
    rst_n = 1'b1;

    // addi $2,$1,-4
    id_valid = 1'b1; id_instr = itype(6'h08, 5'd1, 5'd2, 16'hFFFC);
    id_rs_val = 32'd10; id_rt_val = 32'd99;
    @(negedge clk);
    check("addi_valid", ex_valid, 1);
    check("addi_alu", alu_ctrl, 1);
    check("addi_d1", data1, 32'd10);
    check("addi_d2", data2, 32'hFFFF_FFFC);
    check("addi_rd", ex_rd, 2);
    check("addi_we", ex_wr_en, 1);

    // sll $3,$4,5
    id_instr = rtype(5'd0, 5'd4, 5'd3, 5'd5, 6'h00); id_rs_val = 32'd55; id_rt_val = 32'd7;
    @(negedge clk);
    check("sll_alu", alu_ctrl, 8);
    check("sll_shamt", shamt, 5);
    check("sll_d1", data1, 32'd7);
    check("sll_rd", ex_rd, 3);

    // ori $5,$0,FFFF
    id_instr = itype(6'h0D, 5'd0, 5'd5, 16'hFFFF); id_rs_val = 32'd0;
    @(negedge clk);
    check("ori_alu", alu_ctrl, 4);
    check("ori_d2", data2, 32'h0000_FFFF);
    check("ori_d1", data1, 0);

    // add $9,$6,$0 then exercise the bypass paths
    id_instr = rtype(5'd6, 5'd0, 5'd9, 5'd0, 6'h20); id_rs_val = 32'h11; id_rt_val = 32'h22;
    @(negedge clk);
    check("add_d1_nofwd", data1, 32'h11);
    exm_wr_en = 1'b1; exm_rd = 5'd6; exm_res = 32'hAA;
    mwb_wr_en = 1'b1; mwb_rd = 5'd6; mwb_data = 32'hBB;
    #1 check("fwd_exm_wins", data1, 32'hAA);
    exm_wr_en = 1'b0;
    #1 check("fwd_mwb", data1, 32'hBB);
    exm_wr_en = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
    // sw $7,4($6) presented for the next edge
    id_instr = itype(6'h2B, 5'd6, 5'd7, 16'h0004); id_rs_val = 32'h100; id_rt_val = 32'h55;
    #1 check("fwd_r0_d2", data2, 32'h22);
    check("fwd_r0_d1", data1, 32'h11);
    clear_fwd();

    @(negedge clk);
    check("sw_store", ex_is_store, 1);
    check("sw_we", ex_wr_en, 0);
    check("sw_d1", data1, 32'h100);
    check("sw_d2", data2, 32'h4);
    exm_wr_en = 1'b1; exm_rd = 5'd7; exm_res = 32'h77;
    mwb_wr_en = 1'b1; mwb_rd = 5'd7; mwb_data = 32'hBB;
    #1 check("sw_sdata_fwd", ex_store_data, 32'h77);
    check("sw_imm_nofwd", data2, 32'h4);
    clear_fwd();

    // lw $7,0($1) followed by dependent add $8,$7,$1
    id_instr = itype(6'h23, 5'd1, 5'd7, 16'h0000); id_rs_val = 32'h40;
    @(negedge clk);
    check("lw_load", ex_is_load, 1);
    check("lw_rd", ex_rd, 7);
    check("lw_d1", data1, 32'h40);
    id_instr = rtype(5'd7, 5'd1, 5'd8, 5'd0, 6'h20); id_rs_val = 32'h0; id_rt_val = 32'h3;
    #1 check("lu_stall", stall_req, 1);
    @(negedge clk);
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_alu", alu_ctrl, 0);
    check("lu_stall_clr", stall_req, 0);
    @(negedge clk);
    check("lu_issue_valid", ex_valid, 1);
    check("lu_issue_alu", alu_ctrl, 1);
    check("lu_issue_rd", ex_rd, 8);

    // stall_in holds ID/EX
    stall_in = 1'b1; id_instr = itype(6'h08, 5'd1, 5'd2, 16'h0001);
    @(negedge clk);
    check("hold_rd", ex_rd, 8);
    check("hold_alu", alu_ctrl, 1);
    check("hold_valid", ex_valid, 1);

    // flush beats stall
    flush_in = 1'b1;
    @(negedge clk);
    check("flush_valid", ex_valid, 0);
    check("flush_alu", alu_ctrl, 0);
    flush_in = 1'b0; stall_in = 1'b0;

    // undecodable opcode 3F
    id_instr = {6'h3F, 5'd1, 5'd2, 16'h1234};
    @(negedge clk);
    check("ill_valid", ex_valid, 1);
    check("ill_flag", ex_illegal, 1);
    check("ill_we", ex_wr_en, 0);
    check("ill_alu", alu_ctrl, 0);

    // addi $0,$1,1: write to $0 suppressed
    id_instr = itype(6'h08, 5'd1, 5'd0, 16'h0001); id_rs_val = 32'd10;
    @(negedge clk);
    check("r0_we", ex_wr_en, 0);
    check("r0_alu", alu_ctrl, 1);
    check("r0_ill", ex_illegal, 0);

    // asynchronous reset while stalled
    stall_in = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("arst_valid", ex_valid, 0);
    check("arst_alu", alu_ctrl, 0);
    check("arst_d1", data1, 0);
    check("arst_d2", data2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_hold_valid", ex_valid, 0);
    check("arst_hold_d1", data1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that drives the ALU operand and control interface: alu_ctrl, shamt, data1, data2.
- Decodes the ID-stage instruction into the 4-bit ALU op code and selects the immediate or register operand.
- Registers the result into ID/EX and applies EX-stage forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and handles stall and flush, so it is the initiator side of the ALU interface.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_instr  in  DW  instruction word.
- id_rs_val  in  DW  register-file read of rs.
- id_rt_val  in  DW  register-file read of rt.
- stall_in  in  1  downstream stall: hold ID/EX.
- flush_in  in  1  branch flush: bubble ID/EX.
- exm_wr_en  in  1  EX/MEM writes a register.
- exm_rd  in  RW  EX/MEM destination register.
- exm_res  in  DW  EX/MEM ALU result.
- mwb_wr_en  in  1  MEM/WB writes a register.
- mwb_rd  in  RW  MEM/WB destination register.
- mwb_data  in  DW  MEM/WB writeback data.
- stall_req  out  1  load-use stall request to PC and IF/ID (combinational).
- ex_valid  out  1  EX holds a valid op.
- alu_ctrl  out  4  ALU op code (registered).
- shamt  out  6  shift amount, {1'b0, instr[10:6]} (registered).
- data1  out  DW  ALU operand 1 (forwarded, combinational).
- data2  out  DW  ALU operand 2 (forwarded or immediate, combinational).
- ex_rd  out  RW  destination register.
- ex_wr_en  out  1  EX op writes a register.
- ex_is_load  out  1  EX op is lw.
- ex_is_store  out  1  EX op is sw.
- ex_store_data  out  DW  forwarded rt value for sw.
- ex_illegal  out  1  EX op was an undecodable instruction.

Behaviour:
- Reset (async, rst_n=0): every ID/EX register clears; ex_valid=0, alu_ctrl=0 (NOP), shamt=0, ex_rd=0, all flags 0; data1/data2 then evaluate to 0.
- ALU op codes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, LUI=6, SLT=7, SLL=8, SRL=9.
- R-type (opcode 0), dest=rd:
  - funct 20/21 -> ADD; 22/23 -> SUB; 24 -> AND; 25 -> OR; 26 -> XOR; 2A -> SLT.
  - funct 00 -> SLL and 02 -> SRL: data1 carries rt, since the ALU shifts data1.
- I-type, dest=rt:
  - 08/09 addi -> ADD, sign-extended imm; 0A slti -> SLT, sign-extended.
  - 0C/0D/0E andi/ori/xori -> AND/OR/XOR, zero-extended imm; 0F lui -> LUI, data2 = zero-extended imm.
  - 23 lw -> ADD, sign-extended, ex_is_load=1; 2B sw -> ADD, sign-extended, ex_is_store=1, ex_wr_en=0.
  - 04 beq -> SUB, data2=rt, ex_wr_en=0.
- Anything else: alu_ctrl=NOP, ex_wr_en=0, ex_illegal=1.
- ex_wr_en is forced to 0 when dest=0.
- Latency: one cycle from ID to EX outputs.
- Register update priority at each clk edge: flush_in (bubble: ex_valid=0, all flags 0, alu_ctrl=NOP) > stall_in (hold all) > stall_req (bubble) > load the decoded ID op.
- stall_req = ex_valid & ex_is_load & ex_rd!=0 & id_valid & (ex_rd==id rs-used | ex_rd==id rt-used).
  - rs-used: every op except SLL, SRL, LUI.
  - rt-used: R-type, sw, beq.
- Forwarding applies to the registered rs/rt values, per source operand:
  - exm_wr_en & exm_rd!=0 & exm_rd==reg -> exm_res.
  - else mwb_wr_en & mwb_rd!=0 & mwb_rd==reg -> mwb_data.
  - else the registered value. EX/MEM wins over MEM/WB.
- The immediate is never forwarded. Register 0 reads as the registered value, never forwarded.
- Simultaneous flush_in and stall_in: flush wins.
- Reset mid-stall: all registers clear; no held state survives.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op localparams NOP through SRL, shared with the ALU.
  - Opcode and funct constants.
  - Type width localparams.
- Sub-module fwd_mux instantiated three times (data1, data2-register path, store data): inputs reg index, registered value, EX/MEM and MEM/WB ports; output forwarded value.

Test Plan:
- Reset with rst_n=0 mid-run -> ex_valid=0, alu_ctrl=0, data1=data2=0 immediately, no clock needed.
- addi $2,$1,-4 with id_rs_val=10 -> next cycle alu_ctrl=1, data1=10, data2=FFFFFFFC, ex_rd=2, ex_wr_en=1.
- sll $3,$4,5 with rt_val=7 -> alu_ctrl=8, shamt=5, data1=7; ori $5,$0,FFFF -> alu_ctrl=4, data2=0000FFFF.
- Forwarding: EX op rs=$6, exm_rd=6 (exm_res=AA), mwb_rd=6 (mwb_data=BB) -> data1=AA; exm_wr_en=0 -> data1=BB; rs=$0 with exm_rd=0 -> no forward.
- lw $7 in EX, add $8,$7,$1 in ID -> stall_req=1 for one cycle, then ex_valid=0 bubble, then the add issues.
- flush_in=1 and stall_in=1 on the same edge -> ex_valid=0, alu_ctrl=0; undecodable opcode 3F -> ex_illegal=1, ex_wr_en=0.
